pep_batch_scheduler: RTL and testbench
======================================

PEP_BATCH_SCHEDULER -- requirements
Module: pep_batch_scheduler

Interface
REQ-001 SHALL have parameter BATCH_PBS_NB, default 12, meaning maximum number of PBS per issued batch.
REQ-002 SHALL have parameter TOTAL_PBS_NB, default 32, meaning number of PBS slots stored in HPU; pid range 0..TOTAL_PBS_NB-1.
REQ-003 SHALL have parameter TIMEOUT_W, default 16, meaning width of the flush-timeout counter.
REQ-004 SHALL have port clk, input, 1, meaning the single clock.
REQ-005 SHALL have port s_rst, input, 1, meaning synchronous active-high reset.
REQ-006 SHALL have port cfg_timeout, input, TIMEOUT_W, meaning the number of idle-fill cycles before a partial batch is flushed.
REQ-007 SHALL have port flush, input, 1, meaning a pulse that forces issue of a partial batch.
REQ-008 SHALL have port rdy_vld, input, 1, meaning that a PBS slot has finished loading and is ready.
REQ-009 SHALL have port rdy_pid, input, PID_W=$clog2(TOTAL_PBS_NB), meaning the pid of that slot.
REQ-010 SHALL have port batch_vld, output, 1, meaning a batch command is valid.
REQ-011 SHALL have port batch_rdy, input, 1, meaning the processing pipe accepts the command.
REQ-012 SHALL have port batch_mask, output, TOTAL_PBS_NB, meaning one bit per pid included in the batch.
REQ-013 SHALL have port batch_pbs_nb, output, $clog2(BATCH_PBS_NB+1), meaning the popcount of batch_mask.
REQ-014 SHALL have port batch_done, input, 1, meaning a pulse that the in-flight batch has completed.
REQ-015 SHALL have port release_vld, output, 1, meaning a one-cycle pulse that frees slots.
REQ-016 SHALL have port release_mask, output, TOTAL_PBS_NB, meaning the slots being freed.
REQ-017 SHALL have port busy, output, 1, meaning that a batch is issued or in flight.
REQ-018 SHALL have port err, output, 1, meaning a sticky protocol error flag.

Function
REQ-019 SHALL hold a ready_mask register: bit[rdy_pid] set on rdy_vld; ready_cnt SHALL equal popcount(ready_mask).
REQ-020 SHALL implement FSM IDLE -> FILL -> ISSUE -> RUN -> IDLE; only one batch in flight (BATCH_NB=1).
REQ-021 IDLE: on ready_cnt>0 SHALL go to FILL with timer cleared.
REQ-022 FILL: timer SHALL increment each cycle and saturate; SHALL go to ISSUE when ready_cnt>=BATCH_PBS_NB, or timer>=cfg_timeout, or flush=1.
REQ-023 On entry to ISSUE, SHALL select the lowest-indexed min(ready_cnt,BATCH_PBS_NB) set bits of ready_mask.
REQ-024 The selection SHALL be registered into batch_mask and batch_pbs_nb, with the selected bits cleared from ready_mask in the same cycle.
REQ-025 ISSUE: batch_vld=1, and batch_mask/batch_pbs_nb SHALL remain stable until batch_vld&&batch_rdy; then SHALL go to RUN.
REQ-026 RUN: on batch_done SHALL pulse release_vld for 1 cycle with release_mask=batch_mask, then go to IDLE; if ready_cnt>0 SHALL go directly to FILL.
REQ-027 cfg_timeout=0 SHALL issue one cycle after entering FILL.
REQ-028 rdy_vld arriving in the selection cycle SHALL be kept in ready_mask and excluded from the current batch.
REQ-029 rdy_vld for a pid already in ready_mask or in the in-flight batch SHALL be ignored and set err.
REQ-030 batch_done outside RUN SHALL be ignored and set err.
REQ-031 flush in IDLE with ready_cnt=0 SHALL have no effect.
REQ-032 busy SHALL be 1 in ISSUE and RUN, and 0 otherwise.
REQ-033 batch_vld SHALL be registered, with no combinational path from batch_rdy to batch_vld.

Reset
REQ-034 On s_rst=1 at a clock edge, state SHALL become IDLE and ready_mask, batch_mask, batch_pbs_nb, timer and err SHALL be cleared; batch_vld=0, release_vld=0, release_mask=0, busy=0.
REQ-035 Reset mid-RUN SHALL discard the in-flight batch without a release pulse.

Structure
REQ-036 BATCH_PBS_NB, TOTAL_PBS_NB and the FSM state enum type SHALL come from the shared pep batch/common parameter packages, with no local redefinition.
REQ-037 The lowest-N set-bit selector SHALL be a sub-module pep_batch_sched_select (inputs mask and limit; outputs selected mask and count).

Verification
REQ-038 Reset, then 12 rdy_vld pids 0..11 -> ISSUE with batch_mask=0x00000FFF, batch_pbs_nb=12, before the timeout.
REQ-039 cfg_timeout=5, pids 3,7 -> after 5 FILL cycles, batch_mask=0x00000088, batch_pbs_nb=2.
REQ-040 14 pids 0..13, then batch_done -> batch 0x0FFF, release_mask=0x0FFF pulse, then FILL with ready_mask=0x3000.
REQ-041 batch_rdy held 0 for 10 cycles -> batch_vld and batch_mask stable; rdy_vld pid 20 during ISSUE -> ready_mask bit 20 set.
REQ-042 Duplicate rdy_pid 5, and batch_done in IDLE -> err=1 sticky, with no state change.
REQ-043 s_rst during RUN -> no release_vld; all outputs at reset values next cycle.

Source files
------------

// File: rtl/pep_batch_scheduler_pkg.sv
// ============================================================================
// pep_batch_scheduler_pkg : shared batch sizing and scheduler state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package pep_batch_scheduler_pkg;

    localparam int BATCH_PBS_NB = 12;
    localparam int TOTAL_PBS_NB = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_ISSUE = 2'd2,
        S_RUN   = 2'd3
    } sched_state_e;

endpackage

`default_nettype wire

// File: rtl/pep_batch_scheduler_if.sv
// ============================================================================
// pep_batch_scheduler_if : batch command / completion / release bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface pep_batch_scheduler_if #(
    parameter int TOTAL_PBS_NB = pep_batch_scheduler_pkg::TOTAL_PBS_NB,
    parameter int CNT_W        = $clog2(pep_batch_scheduler_pkg::BATCH_PBS_NB + 1)
);
    logic                    batch_vld;
    logic                    batch_rdy;
    logic [TOTAL_PBS_NB-1:0] batch_mask;
    logic [CNT_W-1:0]        batch_pbs_nb;
    logic                    batch_done;
    logic                    release_vld;
    logic [TOTAL_PBS_NB-1:0] release_mask;

    modport master (
        output batch_vld, batch_mask, batch_pbs_nb, release_vld, release_mask,
        input  batch_rdy, batch_done
    );

    modport slave (
        input  batch_vld, batch_mask, batch_pbs_nb, release_vld, release_mask,
        output batch_rdy, batch_done
    );
endinterface

`default_nettype wire

// File: rtl/pep_batch_sched_select.sv
// ============================================================================
// pep_batch_sched_select : keeps the lowest-indexed set bits of mask, up to limit
// Rev 1.0
// ============================================================================
`default_nettype none

module pep_batch_sched_select #(
    parameter int MASK_W = 32,
    parameter int CNT_W  = 4
) (
    input  wire logic [MASK_W-1:0] mask,
    input  wire logic [CNT_W-1:0]  limit,
    output logic      [MASK_W-1:0] sel_mask,
    output logic      [CNT_W-1:0]  sel_cnt
);

    always_comb begin
        sel_mask = '0;
        sel_cnt  = '0;
        for (int i = 0; i < MASK_W; i++) begin
            if (mask[i] && (sel_cnt < limit)) begin
                sel_mask[i] = 1'b1;
                sel_cnt     = sel_cnt + CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/pep_batch_scheduler.sv
// ============================================================================
// pep_batch_scheduler : gathers ready PBS slots into batches, one in flight
// Rev 1.0
// ============================================================================
`default_nettype none

module pep_batch_scheduler
    import pep_batch_scheduler_pkg::*;
#(
    parameter int BATCH_PBS_NB = pep_batch_scheduler_pkg::BATCH_PBS_NB,
    parameter int TOTAL_PBS_NB = pep_batch_scheduler_pkg::TOTAL_PBS_NB,
    parameter int TIMEOUT_W    = 16,
    localparam int PID_W       = $clog2(TOTAL_PBS_NB),
    localparam int CNT_W       = $clog2(BATCH_PBS_NB + 1),
    localparam int RC_W        = $clog2(TOTAL_PBS_NB + 1)
) (
    input  wire logic                 clk,
    input  wire logic                 s_rst,
    input  wire logic [TIMEOUT_W-1:0] cfg_timeout,
    input  wire logic                 flush,
    input  wire logic                 rdy_vld,
    input  wire logic [PID_W-1:0]     rdy_pid,
    pep_batch_scheduler_if.master     bif,
    output logic                      busy,
    output logic                      err
);

    localparam logic [RC_W-1:0]  c_batch_thr   = RC_W'(BATCH_PBS_NB);
    localparam logic [CNT_W-1:0] c_batch_limit = CNT_W'(BATCH_PBS_NB);

    sched_state_e            r_state;
    sched_state_e            w_state_nxt;
    logic                    w_issue;

    logic [TOTAL_PBS_NB-1:0] r_ready_mask;
    logic [RC_W-1:0]         w_ready_cnt;
    logic [TOTAL_PBS_NB-1:0] r_batch_mask;
    logic [CNT_W-1:0]        r_batch_cnt;
    logic                    r_batch_vld;
    logic                    r_release_vld;
    logic [TOTAL_PBS_NB-1:0] r_release_mask;
    logic [TIMEOUT_W-1:0]    r_timer;
    logic                    r_err;

    logic [TOTAL_PBS_NB-1:0] w_sel_mask;
    logic [CNT_W-1:0]        w_sel_cnt;
    logic [TOTAL_PBS_NB-1:0] w_pid_onehot;
    logic [TOTAL_PBS_NB-1:0] w_inflight;
    logic                    w_busy;
    logic                    w_dup;
    logic                    w_accept;
    logic                    w_done_ok;
    logic                    w_err_evt;

    pep_batch_sched_select #(
        .MASK_W (TOTAL_PBS_NB),
        .CNT_W  (CNT_W)
    ) u_select (
        .mask     (r_ready_mask),
        .limit    (c_batch_limit),
        .sel_mask (w_sel_mask),
        .sel_cnt  (w_sel_cnt)
    );

    always_comb begin
        w_ready_cnt = '0;
        for (int i = 0; i < TOTAL_PBS_NB; i++) begin
            w_ready_cnt = w_ready_cnt + RC_W'(r_ready_mask[i]);
        end
    end

    // An out-of-range pid shifts to an all-zero one-hot and is silently dropped.
    assign w_pid_onehot = TOTAL_PBS_NB'(1) << rdy_pid;
    assign w_busy       = (r_state == S_ISSUE) || (r_state == S_RUN);
    assign w_inflight   = w_busy ? r_batch_mask : '0;
    assign w_dup        = rdy_vld && (|(w_pid_onehot & (r_ready_mask | w_inflight)));
    assign w_accept     = rdy_vld && !w_dup;
    assign w_done_ok    = bif.batch_done && (r_state == S_RUN);
    assign w_err_evt    = w_dup || (bif.batch_done && (r_state != S_RUN));

    always_ff @(posedge clk) begin
        if (s_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_ready_cnt != '0) begin
                    w_state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                if ((w_ready_cnt >= c_batch_thr) || (r_timer >= cfg_timeout) || flush) begin
                    w_state_nxt = S_ISSUE;
                    w_issue     = 1'b1;
                end
            end
            S_ISSUE: begin
                if (r_batch_vld && bif.batch_rdy) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (bif.batch_done) begin
                    w_state_nxt = (w_ready_cnt != '0) ? S_FILL : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A pid arriving in the selection cycle is not in r_ready_mask yet, so it
    // survives the clear and waits for the next batch.
    always_ff @(posedge clk) begin
        if (s_rst) begin
            r_ready_mask   <= '0;
            r_batch_mask   <= '0;
            r_batch_cnt    <= '0;
            r_batch_vld    <= 1'b0;
            r_release_vld  <= 1'b0;
            r_release_mask <= '0;
            r_timer        <= '0;
            r_err          <= 1'b0;
        end else begin
            r_ready_mask <= (r_ready_mask & ~(w_issue ? w_sel_mask : '0))
                          | (w_accept ? w_pid_onehot : '0);
            if (w_issue) begin
                r_batch_mask <= w_sel_mask;
                r_batch_cnt  <= w_sel_cnt;
            end
            r_batch_vld    <= (w_state_nxt == S_ISSUE);
            r_release_vld  <= w_done_ok;
            r_release_mask <= w_done_ok ? r_batch_mask : '0;
            if (r_state == S_FILL) begin
                if (r_timer != '1) begin
                    r_timer <= r_timer + TIMEOUT_W'(1);
                end
            end else begin
                r_timer <= '0;
            end
            if (w_err_evt) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bif.batch_vld    = r_batch_vld;
    assign bif.batch_mask   = r_batch_mask;
    assign bif.batch_pbs_nb = r_batch_cnt;
    assign bif.release_vld  = r_release_vld;
    assign bif.release_mask = r_release_mask;
    assign busy             = w_busy;
    assign err              = r_err;

endmodule

`default_nettype wire

// File: tb/tb_pep_batch_scheduler.sv
// ============================================================================
// tb_pep_batch_scheduler : directed self-checking bench for pep_batch_scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pep_batch_scheduler;
    import pep_batch_scheduler_pkg::*;

    logic        clk;
    logic        s_rst;
    logic [15:0] cfg_timeout;
    logic        flush;
    logic        rdy_vld;
    logic [4:0]  rdy_pid;
    logic        busy;
    logic        err;

    int n_checks;
    int n_fail;

    pep_batch_scheduler_if bif ();

    pep_batch_scheduler dut (
        .clk         (clk),
        .s_rst       (s_rst),
        .cfg_timeout (cfg_timeout),
        .flush       (flush),
        .rdy_vld     (rdy_vld),
        .rdy_pid     (rdy_pid),
        .bif         (bif),
        .busy        (busy),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        s_rst = 1'b1;
        tick();
        tick();
        s_rst = 1'b0;
    endtask

    task automatic push(input int pid);
        rdy_vld = 1'b1;
        rdy_pid = 5'(pid);
        tick();
        rdy_vld = 1'b0;
    endtask

    task automatic wait_vld(input string tag, input int max, output int n);
        n = 0;
        while (bif.batch_vld !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        chk(tag, 64'(bif.batch_vld), 64'd1);
    endtask

    task automatic accept();
        bif.batch_rdy = 1'b1;
        tick();
        bif.batch_rdy = 1'b0;
    endtask

    task automatic done();
        bif.batch_done = 1'b1;
        tick();
        bif.batch_done = 1'b0;
    endtask

    initial begin
        int n;
        logic        flag;
        logic [31:0] m0;

        n_checks       = 0;
        n_fail         = 0;
        s_rst          = 1'b0;
        cfg_timeout    = 16'd1000;
        flush          = 1'b0;
        rdy_vld        = 1'b0;
        rdy_pid        = '0;
        bif.batch_rdy  = 1'b0;
        bif.batch_done = 1'b0;

        // Reset state and full batch of 12
        do_reset();
        chk("rst_vld", 64'(bif.batch_vld), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_rel", 64'(bif.release_vld), 64'd0);
        chk("rst_relmask", 64'(bif.release_mask), 64'd0);
        chk("rst_mask", 64'(bif.batch_mask), 64'd0);
        chk("rst_nb", 64'(bif.batch_pbs_nb), 64'd0);

        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        chk("flush_empty_busy", 64'(busy), 64'd0);
        chk("flush_empty_state", 64'(dut.r_state), 64'(S_IDLE));

        for (int i = 0; i < 12; i++) push(i);
        wait_vld("full_vld", 4, n);
        chk("full_mask", 64'(bif.batch_mask), 64'h0FFF);
        chk("full_nb", 64'(bif.batch_pbs_nb), 64'd12);
        chk("full_busy", 64'(busy), 64'd1);

        // Backpressure hold; pid 20 arrives during ISSUE
        m0   = bif.batch_mask;
        flag = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) push(20);
            else tick();
            if (bif.batch_vld !== 1'b1 || bif.batch_mask !== m0 || bif.batch_pbs_nb !== 4'd12)
                flag = 1'b1;
        end
        chk("hold_stable", 64'(flag), 64'd0);
        chk("hold_ready20", 64'(dut.r_ready_mask), 64'h0010_0000);

        accept();
        chk("run_vld", 64'(bif.batch_vld), 64'd0);
        chk("run_busy", 64'(busy), 64'd1);
        done();
        chk("rel1_vld", 64'(bif.release_vld), 64'd1);
        chk("rel1_mask", 64'(bif.release_mask), 64'h0FFF);
        chk("rel1_fill", 64'(dut.r_state), 64'(S_FILL));

        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("rel1_pulse_end", 64'(bif.release_vld), 64'd0);
        chk("flush_vld", 64'(bif.batch_vld), 64'd1);
        chk("flush_mask", 64'(bif.batch_mask), 64'h0010_0000);
        chk("flush_nb", 64'(bif.batch_pbs_nb), 64'd1);
        accept();
        done();
        chk("rel2_mask", 64'(bif.release_mask), 64'h0010_0000);

        // Timeout-driven partial batch
        do_reset();
        cfg_timeout = 16'd5;
        push(3);
        push(7);
        wait_vld("to_vld", 20, n);
        chk("to_latency", 64'(n >= 5 && n <= 7), 64'd1);
        chk("to_mask", 64'(bif.batch_mask), 64'h88);
        chk("to_nb", 64'(bif.batch_pbs_nb), 64'd2);
        accept();
        done();
        tick();

        // Zero timeout issues one cycle after entering FILL
        cfg_timeout = 16'd0;
        push(9);
        wait_vld("t0_vld", 10, n);
        chk("t0_latency", 64'(n), 64'd2);
        chk("t0_mask", 64'(bif.batch_mask), 64'h200);
        accept();
        done();
        tick();

        // 14 pids: overflow pids stay ready for the next batch
        do_reset();
        cfg_timeout = 16'd1000;
        for (int i = 0; i < 14; i++) push(i);
        wait_vld("ovf_vld", 4, n);
        chk("ovf_mask", 64'(bif.batch_mask), 64'h0FFF);
        chk("ovf_nb", 64'(bif.batch_pbs_nb), 64'd12);
        accept();
        done();
        chk("ovf_rel_vld", 64'(bif.release_vld), 64'd1);
        chk("ovf_rel_mask", 64'(bif.release_mask), 64'h0FFF);
        chk("ovf_fill", 64'(dut.r_state), 64'(S_FILL));
        chk("ovf_ready", 64'(dut.r_ready_mask), 64'h3000);

        // Protocol errors
        do_reset();
        done();
        chk("err_done_idle", 64'(err), 64'd1);
        chk("err_done_state", 64'(dut.r_state), 64'(S_IDLE));
        chk("err_done_rel", 64'(bif.release_vld), 64'd0);
        push(5);
        push(5);
        chk("err_dup_ready", 64'(dut.r_ready_mask), 64'h20);
        tick();
        tick();
        chk("err_sticky", 64'(err), 64'd1);
        done();
        chk("err_done_fill", 64'(dut.r_state), 64'(S_FILL));

        // Reset while a batch is running
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("rr_mask", 64'(bif.batch_mask), 64'h20);
        accept();
        chk("rr_busy", 64'(busy), 64'd1);
        s_rst          = 1'b1;
        bif.batch_done = 1'b1;
        tick();
        s_rst          = 1'b0;
        bif.batch_done = 1'b0;
        chk("rr_rel", 64'(bif.release_vld), 64'd0);
        chk("rr_busy0", 64'(busy), 64'd0);
        chk("rr_err", 64'(err), 64'd0);
        chk("rr_vld", 64'(bif.batch_vld), 64'd0);
        chk("rr_bmask", 64'(bif.batch_mask), 64'd0);
        chk("rr_nb", 64'(bif.batch_pbs_nb), 64'd0);
        chk("rr_ready", 64'(dut.r_ready_mask), 64'd0);
        tick();
        chk("rr_rel_after", 64'(bif.release_vld), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
